// File: rtl/layer_three.sv
// Final binary FC layer: XNOR-popcount of 196 input bits against ten weight rows.
// One 49-bit chunk per enabled cycle; running argmax drives digit.
module layer_three #(
  parameter logic [1959:0] WEIGHTS3 = 1960'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   state,
  input  logic [195:0] pixels,
  output logic [79:0]  class_scores,
  output logic [3:0]   digit,
  output logic         done
);

  localparam logic [2:0] s_LAYER_3 = 3'b100;

  logic [1:0]   chunk_q, chunk_d;
  logic [3:0]   cls_q, cls_d;
  logic [7:0]   acc_q, acc_d;
  logic [7:0]   best_q, best_d;
  logic [79:0]  scores_q, scores_d;
  logic [3:0]   digit_q, digit_d;
  logic         done_q, done_d;

  logic [195:0] cls_w;
  logic [48:0]  w_chunk, p_chunk, match;
  logic [5:0]   pc;
  logic [7:0]   final_score;
  logic         en;

  // Weight row for the current class; cls == 10 only occurs once done, so zero is harmless.
  always_comb begin
    cls_w = '0;
    for (int c = 0; c < 10; c++) begin
      if (cls_q == 4'(c)) cls_w = WEIGHTS3[c*196 +: 196];
    end
  end

  always_comb begin
    unique case (chunk_q)
      2'd0: begin w_chunk = cls_w[0   +: 49]; p_chunk = pixels[0   +: 49]; end
      2'd1: begin w_chunk = cls_w[49  +: 49]; p_chunk = pixels[49  +: 49]; end
      2'd2: begin w_chunk = cls_w[98  +: 49]; p_chunk = pixels[98  +: 49]; end
      2'd3: begin w_chunk = cls_w[147 +: 49]; p_chunk = pixels[147 +: 49]; end
      default: begin w_chunk = '0; p_chunk = '0; end
    endcase
  end

  always_comb begin
    match = ~(p_chunk ^ w_chunk);
    pc    = '0;
    for (int i = 0; i < 49; i++) pc = pc + 6'(match[i]);
    final_score = acc_q + 8'(pc);
  end

  assign en = (state == s_LAYER_3) && !done_q;

  always_comb begin
    chunk_d  = chunk_q;
    cls_d    = cls_q;
    acc_d    = acc_q;
    best_d   = best_q;
    scores_d = scores_q;
    digit_d  = digit_q;
    done_d   = done_q;
    if (en) begin
      if (chunk_q != 2'd3) begin
        acc_d   = final_score;
        chunk_d = chunk_q + 2'd1;
      end else begin
        for (int c = 0; c < 10; c++) begin
          if (cls_q == 4'(c)) scores_d[c*8 +: 8] = final_score;
        end
        acc_d   = '0;
        chunk_d = '0;
        cls_d   = cls_q + 4'd1;
        // Strict compare keeps the lowest class index on ties.
        if (cls_q == 4'd0 || final_score > best_q) begin
          best_d  = final_score;
          digit_d = cls_q;
        end
        if (cls_q == 4'd9) done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chunk_q  <= '0;
      cls_q    <= '0;
      acc_q    <= '0;
      best_q   <= '0;
      scores_q <= '0;
      digit_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      chunk_q  <= chunk_d;
      cls_q    <= cls_d;
      acc_q    <= acc_d;
      best_q   <= best_d;
      scores_q <= scores_d;
      digit_q  <= digit_d;
      done_q   <= done_d;
    end
  end

  assign class_scores = scores_q;
  assign digit        = digit_q;
  assign done         = done_q;

endmodule

// File: tb/tb_layer_three.sv
// Bench for layer_three: three instances (all-zero, single-match, tie weights) share
// clock/reset/state; expected scores come from a whole-vector XNOR-popcount model.
module tb_layer_three;

  localparam logic [195:0] P    = {4{49'h1_5A5A_C3C3_0F0F}};
  localparam logic [1959:0] WZ  = '0;
  localparam logic [1959:0] WM  = {~P, ~P, P, ~P, ~P, ~P, ~P, ~P, ~P, ~P};
  localparam logic [195:0] W100 = {96'b0, {100{1'b1}}};
  localparam logic [195:0] W47  = {149'b0, {47{1'b1}}};
  localparam logic [195:0] W46  = {150'b0, {46{1'b1}}};
  localparam logic [1959:0] WT  = {W100, W100, W100, W47, W46, W47, W46, W100, W100, W100};

  typedef struct {
    int          sel;
    logic [79:0] scores;
    logic [3:0]  digit;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  state = 3'b000;
  logic [79:0] sc [3];
  logic [3:0]  dg [3];
  logic        dn [3];

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  layer_three #(.WEIGHTS3(WZ)) u_zero (
    .clk(clk), .rst(rst), .state(state), .pixels(196'b0),
    .class_scores(sc[0]), .digit(dg[0]), .done(dn[0])
  );
  layer_three #(.WEIGHTS3(WM)) u_match (
    .clk(clk), .rst(rst), .state(state), .pixels(P),
    .class_scores(sc[1]), .digit(dg[1]), .done(dn[1])
  );
  layer_three #(.WEIGHTS3(WT)) u_tie (
    .clk(clk), .rst(rst), .state(state), .pixels(196'b0),
    .class_scores(sc[2]), .digit(dg[2]), .done(dn[2])
  );

  function automatic logic [79:0] model_scores(input logic [1959:0] w, input logic [195:0] px);
    logic [79:0]  r;
    logic [195:0] x;
    int           n;
    r = '0;
    for (int c = 0; c < 10; c++) begin
      x = ~(px ^ w[c*196 +: 196]);
      n = 0;
      for (int i = 0; i < 196; i++) n += int'(x[i]);
      r[c*8 +: 8] = 8'(n);
    end
    return r;
  endfunction

  function automatic logic [3:0] model_digit(input logic [79:0] s);
    logic [7:0] best;
    logic [3:0] idx;
    best = s[7:0];
    idx  = 4'd0;
    for (int c = 1; c < 10; c++) begin
      if (s[c*8 +: 8] > best) begin
        best = s[c*8 +: 8];
        idx  = 4'(c);
      end
    end
    return idx;
  endfunction

  task automatic push_exp(input int sel);
    exp_t        e;
    logic [1959:0] w;
    logic [195:0]  px;
    case (sel)
      0:       begin w = WZ; px = '0; end
      1:       begin w = WM; px = P;  end
      default: begin w = WT; px = '0; end
    endcase
    e.sel    = sel;
    e.scores = model_scores(w, px);
    e.digit  = model_digit(e.scores);
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    state = 3'b000;
    rst   = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
  endtask

  task automatic run_edges(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    do_reset();
    for (int s = 0; s < 3; s++) begin
      n_tests++;
      if (sc[s] !== 80'b0) begin
        n_fail++; $display("FAIL reset_scores[%0d]: got %h expected 0", s, sc[s]);
      end
      n_tests++;
      if (dg[s] !== 4'd0) begin
        n_fail++; $display("FAIL reset_digit[%0d]: got %0d expected 0", s, dg[s]);
      end
      n_tests++;
      if (dn[s] !== 1'b0) begin
        n_fail++; $display("FAIL reset_done[%0d]: got %b expected 0", s, dn[s]);
      end
    end
  endtask

  task automatic test_all_zero();
    exp_t e;
    do_reset();
    push_exp(0);
    state = 3'b100;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if (dn[0] !== (k == 40)) begin
        n_fail++; $display("FAIL zero_done_edge%0d: got %b expected %b", k, dn[0], k == 40);
      end
    end
    e = sb_q.pop_front();
    n_tests++;
    if (sc[e.sel] !== e.scores || e.scores !== {10{8'hC4}}) begin
      n_fail++; $display("FAIL zero_scores: got %h expected %h", sc[e.sel], {10{8'hC4}});
    end
    n_tests++;
    if (dg[e.sel] !== e.digit) begin
      n_fail++; $display("FAIL zero_digit: got %0d expected %0d", dg[e.sel], e.digit);
    end
  endtask

  task automatic test_single_match();
    exp_t e;
    do_reset();
    push_exp(1);
    state = 3'b100;
    run_edges(40);
    e = sb_q.pop_front();
    n_tests++;
    if (dn[e.sel] !== 1'b1) begin
      n_fail++; $display("FAIL match_done: got %b expected 1", dn[e.sel]);
    end
    n_tests++;
    if (sc[e.sel] !== e.scores) begin
      n_fail++; $display("FAIL match_scores: got %h expected %h", sc[e.sel], e.scores);
    end
    n_tests++;
    if (dg[e.sel] !== 4'd7) begin
      n_fail++; $display("FAIL match_digit: got %0d expected 7", dg[e.sel]);
    end
  endtask

  task automatic test_tie_break();
    exp_t e;
    do_reset();
    push_exp(2);
    state = 3'b100;
    run_edges(40);
    e = sb_q.pop_front();
    n_tests++;
    if (sc[e.sel] !== e.scores) begin
      n_fail++; $display("FAIL tie_scores: got %h expected %h", sc[e.sel], e.scores);
    end
    n_tests++;
    if (sc[e.sel][3*8 +: 8] !== 8'd150 || sc[e.sel][5*8 +: 8] !== 8'd150) begin
      n_fail++; $display("FAIL tie_150: got %0d/%0d expected 150/150",
                         sc[e.sel][3*8 +: 8], sc[e.sel][5*8 +: 8]);
    end
    n_tests++;
    if (dg[e.sel] !== 4'd3) begin
      n_fail++; $display("FAIL tie_digit: got %0d expected 3", dg[e.sel]);
    end
  endtask

  task automatic test_pause();
    exp_t        e;
    logic [79:0] s_snap;
    logic [3:0]  d_snap;
    do_reset();
    push_exp(2);
    state = 3'b100;
    run_edges(17);
    s_snap = sc[2];
    d_snap = dg[2];
    for (int g = 0; g < 5; g++) begin
      state = (g % 2 == 0) ? 3'b000 : 3'b011;
      @(posedge clk); #1;
      n_tests++;
      if (sc[2] !== s_snap || dg[2] !== d_snap || dn[2] !== 1'b0) begin
        n_fail++; $display("FAIL pause_hold%0d: got %h/%0d/%b expected %h/%0d/0",
                           g, sc[2], dg[2], dn[2], s_snap, d_snap);
      end
    end
    state = 3'b100;
    for (int k = 18; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k >= 39) begin
        n_tests++;
        if (dn[2] !== (k == 40)) begin
          n_fail++; $display("FAIL pause_done_edge%0d: got %b expected %b", k, dn[2], k == 40);
        end
      end
    end
    e = sb_q.pop_front();
    n_tests++;
    if (sc[e.sel] !== e.scores || dg[e.sel] !== e.digit) begin
      n_fail++; $display("FAIL pause_result: got %h/%0d expected %h/%0d",
                         sc[e.sel], dg[e.sel], e.scores, e.digit);
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    do_reset();
    push_exp(2);
    state = 3'b100;
    run_edges(20);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++;
    if (sc[2] !== 80'b0 || dg[2] !== 4'd0 || dn[2] !== 1'b0) begin
      n_fail++; $display("FAIL midrst_clear: got %h/%0d/%b expected 0/0/0", sc[2], dg[2], dn[2]);
    end
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k >= 39) begin
        n_tests++;
        if (dn[2] !== (k == 40)) begin
          n_fail++; $display("FAIL midrst_done_edge%0d: got %b expected %b", k, dn[2], k == 40);
        end
      end
    end
    e = sb_q.pop_front();
    n_tests++;
    if (sc[e.sel] !== e.scores || dg[e.sel] !== e.digit) begin
      n_fail++; $display("FAIL midrst_result: got %h/%0d expected %h/%0d",
                         sc[e.sel], dg[e.sel], e.scores, e.digit);
    end
  endtask

  task automatic test_hold();
    exp_t e;
    do_reset();
    push_exp(1);
    state = 3'b100;
    run_edges(45);
    e = sb_q.pop_front();
    for (int h = 0; h < 20; h++) begin
      state = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      n_tests++;
      if (sc[1] !== e.scores || dg[1] !== e.digit || dn[1] !== 1'b1) begin
        n_fail++; $display("FAIL hold%0d: got %h/%0d/%b expected %h/%0d/1",
                           h, sc[1], dg[1], dn[1], e.scores, e.digit);
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_single_match();
    test_tie_break();
    test_pause();
    test_mid_reset();
    test_hold();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
